// File: rtl/softmax_in_frame_buffer.sv
// Single-frame store-and-forward buffer in front of the softmax core: captures one
// AXI-Stream frame of fp32 words, tracks its maximum, then replays it with side-band.
module softmax_in_frame_buffer #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                   axi_clock_i,
  input  logic                   axi_reset_i,
  input  logic                   s_axis_valid_i,
  input  logic [2*DATA_SIZE-1:0] s_axis_data_i,
  input  logic                   s_axis_last_i,
  output logic                   s_axis_ready_o,
  output logic                   m_axis_valid_o,
  output logic [2*DATA_SIZE-1:0] m_axis_data_o,
  output logic                   m_axis_last_o,
  input  logic                   m_axis_ready_i,
  output logic [ADDR_W:0]        frame_len_o,
  output logic [2*DATA_SIZE-1:0] frame_max_o,
  output logic                   overflow_o,
  output logic [1:0]             debug_state_o
);

  localparam int W = 2 * DATA_SIZE;
  localparam logic [W-1:0] NEG_INF = {1'b1, 8'hFF, {(W-9){1'b0}}};

  // Both ports: a beat transfers on a rising edge where valid and ready are both high;
  // valid/data/last are held stable by the sender until that happens, and output valid
  // is a pure function of state (never of m_axis_ready_i).
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DROP  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [W-1:0]      run_max_q;
  logic [ADDR_W:0]   len_q;
  logic [W-1:0]      max_q;
  logic              ovf_q;

  logic              s_hs;
  logic              m_hs;
  logic              wr_full;
  logic              rd_at_end;
  logic [W-1:0]      in_max;

  // Maps fp32 bit patterns onto unsigned keys whose order matches numeric order
  // (with -0 < +0, NaNs ordered by their bits rather than special-cased).
  function automatic logic [W-1:0] order_key(input logic [W-1:0] x);
    return x[W-1] ? ~x : (x ^ {1'b1, {(W-1){1'b0}}});
  endfunction

  assign s_hs      = s_axis_valid_i & s_axis_ready_o;
  assign m_hs      = m_axis_valid_o & m_axis_ready_i;
  assign wr_full   = (wr_ptr_q == ADDR_W'(DEPTH - 1));
  assign rd_at_end = ({1'b0, rd_ptr_q} == (len_q - (ADDR_W+1)'(1)));
  // Strictly greater so that on equal keys the earlier word is kept.
  assign in_max    = (order_key(s_axis_data_i) > order_key(run_max_q)) ? s_axis_data_i
                                                                     : run_max_q;

  // State register.
  always_ff @(posedge axi_clock_i or posedge axi_reset_i) begin
    if (axi_reset_i) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (s_hs) begin
          if (s_axis_last_i) begin
            state_d = ST_DRAIN;
          end else if (wr_full) begin
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (s_hs && s_axis_last_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_hs && rd_at_end) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Outputs; ready is also gated by reset so it reads 0 while reset is held.
  always_comb begin
    s_axis_ready_o = 1'b0;
    m_axis_valid_o = 1'b0;
    m_axis_last_o  = 1'b0;
    m_axis_data_o  = mem[rd_ptr_q];
    case (state_q)
      ST_FILL, ST_DROP: begin
        s_axis_ready_o = ~axi_reset_i;
      end
      ST_DRAIN: begin
        m_axis_valid_o = 1'b1;
        m_axis_last_o  = rd_at_end;
      end
      default: begin
        s_axis_ready_o = 1'b0;
      end
    endcase
  end

  assign frame_len_o   = len_q;
  assign frame_max_o   = max_q;
  assign overflow_o    = ovf_q;
  assign debug_state_o = state_q;

  // Buffer storage carries no reset; contents are only read after being written.
  always_ff @(posedge axi_clock_i) begin
    if (state_q == ST_FILL && s_hs) begin
      mem[wr_ptr_q] <= s_axis_data_i;
    end
  end

  always_ff @(posedge axi_clock_i or posedge axi_reset_i) begin
    if (axi_reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      run_max_q <= NEG_INF;
      len_q     <= '0;
      max_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (s_hs) begin
            wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
            run_max_q <= in_max;
            if (s_axis_last_i || wr_full) begin
              len_q <= {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
              max_q <= in_max;
              ovf_q <= ~s_axis_last_i;
            end
          end
        end
        ST_DRAIN: begin
          if (m_hs) begin
            if (rd_at_end) begin
              wr_ptr_q  <= '0;
              rd_ptr_q  <= '0;
              run_max_q <= NEG_INF;
            end else begin
              rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          wr_ptr_q <= wr_ptr_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_in_frame_buffer.sv
// Randomized and directed bench for softmax_in_frame_buffer, checked against a
// frame-level reference model (truncate to DEPTH, ordered-key maximum).
module tb_softmax_in_frame_buffer;

  localparam int DATA_SIZE = 16;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int W         = 2 * DATA_SIZE;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            s_valid = 1'b0;
  logic [W-1:0]    s_data  = '0;
  logic            s_last  = 1'b0;
  logic            s_ready;
  logic            m_valid;
  logic [W-1:0]    m_data;
  logic            m_last;
  logic            m_ready = 1'b0;
  logic [ADDR_W:0] frame_len;
  logic [W-1:0]    frame_max;
  logic            overflow;
  logic [1:0]      dbg_state;

  softmax_in_frame_buffer #(
    .DATA_SIZE(DATA_SIZE),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) dut (
    .axi_clock_i   (clk),
    .axi_reset_i   (rst),
    .s_axis_valid_i(s_valid),
    .s_axis_data_i (s_data),
    .s_axis_last_i (s_last),
    .s_axis_ready_o(s_ready),
    .m_axis_valid_o(m_valid),
    .m_axis_data_o (m_data),
    .m_axis_last_o (m_last),
    .m_axis_ready_i(m_ready),
    .frame_len_o   (frame_len),
    .frame_max_o   (frame_max),
    .overflow_o    (overflow),
    .debug_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard
  logic [W-1:0] frame_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_len;
  logic [W-1:0] exp_max;
  logic         exp_ovf;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fp_key(input logic [W-1:0] x);
    return x[W-1] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Reference model: keep the first DEPTH words, max starts from -inf.
  task automatic build_expected();
    exp_q.delete();
    exp_max = 32'hFF80_0000;
    foreach (frame_q[i]) begin
      if (i < DEPTH) begin
        exp_q.push_back(frame_q[i]);
        if (fp_key(frame_q[i]) > fp_key(exp_max)) exp_max = frame_q[i];
      end
    end
    exp_len = W'(exp_q.size());
    exp_ovf = (frame_q.size() > DEPTH);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_len", frame_len, 0);
    check_eq("rst_max", frame_max, 0);
    check_eq("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("post_rst_s_ready", s_ready, 1);
  endtask

  // Driver: sends frame_q (with random source gaps), then drains it.
  // stall_mode 0: always ready, 1: ready pattern 1,0,0,... 2: random ready.
  task automatic run_frame(input int stall_mode, input int gap_pct, input int abort_after);
    int i;
    int k;
    int cyc;
    int n;
    build_expected();
    n   = frame_q.size();
    i   = 0;
    cyc = 0;
    while (i < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
      end else begin
        s_valid = 1'b1;
        s_data  = frame_q[i];
        s_last  = (i == n - 1);
        check_eq("s_ready_ingress", s_ready, 1);
        if (s_ready) i++;
      end
    end
    check_eq("fill_timeout", i, n);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_eq("valid_latency", m_valid, 1);
    k   = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      case (stall_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = $urandom_range(0, 1);
      endcase
      check_eq("m_valid", m_valid, 1);
      check_eq("m_data", m_data, exp_q[0]);
      check_eq("m_last", m_last, exp_q.size() == 1);
      check_eq("s_ready_drain", s_ready, 0);
      if (m_ready) begin
        void'(exp_q.pop_front());
        k++;
      end
      @(negedge clk);
      cyc++;
      if (abort_after >= 0 && k == abort_after) begin
        m_ready = 1'b0;
        pulse_reset();
        return;
      end
    end
    check_eq("drain_timeout", exp_q.size(), 0);
    m_ready = 1'b0;
    check_eq("post_valid", m_valid, 0);
    check_eq("post_s_ready", s_ready, 1);
    check_eq("frame_len", frame_len, exp_len);
    check_eq("frame_max", frame_max, exp_max);
    check_eq("overflow", overflow, exp_ovf);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_s_ready", s_ready, 0);
    check_eq("reset_m_valid", m_valid, 0);
    check_eq("reset_len", frame_len, 0);
    check_eq("reset_max", frame_max, 0);
    check_eq("reset_ovf", overflow, 0);
    rst = 1'b0;
    #1;
    check_eq("release_s_ready", s_ready, 1);
    check_eq("release_state_fill", dbg_state, 0);

    frame_q = '{32'hBFE147AE, 32'hC01820C4, 32'h40558106, 32'hC04B74BC, 32'hBF59DB22};
    run_frame(0, 0, -1);
    run_frame(1, 0, -1);

    frame_q = '{32'hC04B74BC, 32'hBF59DB22, 32'hC01820C4};
    run_frame(0, 0, -1);
    frame_q = '{32'h80000000, 32'h00000000};
    run_frame(2, 20, -1);

    frame_q.delete();
    for (int j = 0; j < 20; j++) frame_q.push_back($urandom);
    run_frame(0, 0, -1);
    frame_q = '{32'h3F800000, 32'h40000000, 32'hC0000000};
    run_frame(0, 0, -1);

    frame_q = '{32'h3F800000};
    run_frame(0, 0, -1);
    frame_q = '{32'h41200000, 32'hC1200000};
    run_frame(0, 0, -1);
    frame_q = '{32'h00000001, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800000};
    run_frame(0, 0, -1);

    frame_q = '{32'hBFE147AE, 32'hC01820C4, 32'h40558106, 32'hC04B74BC, 32'hBF59DB22};
    run_frame(0, 0, 2);
    run_frame(0, 0, -1);

    for (int t = 0; t < 14; t++) begin
      int len;
      len = $urandom_range(1, 20);
      frame_q.delete();
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) frame_q.push_back({$urandom_range(0, 1) == 1, 31'h3F800000});
        else frame_q.push_back($urandom);
      end
      run_frame($urandom_range(0, 2), $urandom_range(0, 40), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
